screen_framebuffer: RTL and testbench
=====================================

# screen_framebuffer

Double-buffered pixel frame store between the CPU bus and the 64x64 HUB75 scanner (`screen32x32`). The CPU side writes 12-bit RGB444 pixels, or issues fill and swap commands, into the back bank. The scanner reads two pixels per cycle (top and bottom half at the same index) from the front bank. A swap takes effect only at the scanner's frame boundary, so a frame is never shown half-updated.

## Interface
- `NUM_COLS`, 64, matrix columns
- `NUM_ROWS`, 64, matrix rows
- `BIT_DEPTH`, 4, bits per colour channel; pixel word is 3*BIT_DEPTH bits
- `clk`  in  1  single clock for all logic
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets)
- `wr_valid`  in  1  pixel write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_addr`  in  12  pixel index: row*NUM_COLS+col; bit 11 selects the bottom half
- `wr_data`  in  12  {R[3:0],G[3:0],B[3:0]}
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_op`  in  2  00 nop, 01 fill back bank with `cmd_data`, 10 swap, 11 reserved (nop)
- `cmd_data`  in  12  fill colour
- `busy`  out  1  high in FILL or SWAP_WAIT
- `swap_done`  out  1  one-cycle pulse when the swap commits
- `front_bank`  out  1  bank currently displayed
- `frame_start`  in  1  one-cycle pulse from the scanner at the start of row 0
- `rd_addr`  in  11  half-screen pixel index (0..2047)
- `rd_data0`  out  12  front[rd_addr], top half
- `rd_data1`  out  12  front[rd_addr+2048], bottom half

## Operation
- Storage: 2 banks x 2 halves, each 2048x12. The write port always targets the back bank (`!front_bank`). Reads always come from the front bank.
- FSM states: IDLE, FILL, SWAP_WAIT.
- **IDLE**
  - `wr_ready`=1 and `cmd_ready`=1.
  - An accepted write stores `wr_data` to back[`wr_addr[11]`][`wr_addr[10:0]`].
  - An accepted fill loads `fill_cnt`=0 and moves to FILL.
  - An accepted swap moves to SWAP_WAIT.
  - nop and reserved opcodes are accepted with no effect.
  - A write and a command accepted in the same cycle both take effect. The write lands before the command starts.
- **FILL**
  - `wr_ready`=0 and `cmd_ready`=0.
  - Each cycle writes `cmd_data` (latched at acceptance) to both halves of the back bank at `fill_cnt`, then increments `fill_cnt` (11 bits).
  - After writing index 2047, returns to IDLE. Total duration is 2048 cycles.
- **SWAP_WAIT**
  - `wr_ready`=0 and `cmd_ready`=0.
  - On `frame_start`=1: toggle `front_bank`, pulse `swap_done` in the next cycle, return to IDLE.
  - `frame_start` is ignored in IDLE and FILL, and in the cycle the swap is accepted.
- Reset mid-FILL or mid-SWAP_WAIT aborts the operation. Memory contents are not reset and are left partially filled.

## Timing
- Reset values:
  - `wr_ready`=1, `cmd_ready`=1, `busy`=0, `swap_done`=0, `front_bank`=0
  - `rd_data0`=`rd_data1`=0 until the first clock after reset release
  - state IDLE, `fill_cnt`=0
- Read latency is 1 cycle: `rd_addr` sampled at edge N gives `rd_data*` valid after edge N. Reads are registered and available every cycle.
- `front_bank` changes on the edge that samples `frame_start` in SWAP_WAIT. Reads issued from the next cycle onward see the new bank.
- Write to read-visibility takes one swap: the pixel appears only after a swap has committed.
- Ready signals are Moore outputs of the state register, with no combinational path from valid inputs.
- `busy` = (state != IDLE), registered.

## Structure
- Shared package `screen_pkg`: `NUM_COLS`, `NUM_ROWS`, `BIT_DEPTH`, `HALF_SCREEN`, the pixel-word width, the `cmd_op` encodings, and the FSM state encoding. `screen32x32` imports the same constants.
- One sub-module, `fb_ram`: simple dual-port 2048x12 RAM with 1 write port and 1 registered read port, instantiated 4 times (bank x half).
- The top level holds the FSM, fill counter, bank-select muxing and read output muxing.

## Test plan
- Reset: hold `reset`=0, release → `wr_ready`=1, `cmd_ready`=1, `busy`=0, `front_bank`=0.
- Write 0xF00 at addr 5 and 0x00F at addr 2053, swap, pulse `frame_start`, then read `rd_addr`=5 → `rd_data0`=0xF00, `rd_data1`=0x00F, `front_bank`=1, `swap_done` pulse seen.
- Fill 0x0A0 → `busy` high for exactly 2048 cycles with `wr_ready`=0 throughout. After a swap, every `rd_addr` reads 0x0A0 on both outputs.
- Swap issued, no `frame_start` for 500 cycles → `wr_ready`=0 and `cmd_ready`=0 the whole time, `front_bank` unchanged. The first `frame_start` commits the swap.
- `frame_start` in the same cycle as swap acceptance → ignored. Swap commits on the next pulse.
- Assert reset at fill cycle 100 → after release the FSM is IDLE with `busy`=0. Indices 0..99 of the back bank hold the fill value.

Source files
------------

// File: rtl/screen_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
// Shared constants and types for the HUB75 display path: matrix geometry,
// pixel word width, command opcodes and the frame store FSM state encoding.
// Imported by screen_framebuffer, its RAM sub-module and the scanner.
// -----------------------------------------------------------------------------
package screen_pkg;

   localparam int NUM_COLS    = 64;
   localparam int NUM_ROWS    = 64;
   localparam int BIT_DEPTH   = 4;
   localparam int PIX_W       = 3 * BIT_DEPTH;             // {R,G,B}
   localparam int HALF_SCREEN = (NUM_COLS * NUM_ROWS) / 2;  // pixels per half
   localparam int HALF_AW     = $clog2(HALF_SCREEN);        // 11
   localparam int ADDR_W      = HALF_AW + 1;                // 12, MSB = half

   localparam logic [HALF_AW-1:0] FILL_LAST = HALF_AW'(HALF_SCREEN - 1);

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_FILL = 2'b01,
      CMD_SWAP = 2'b10,
      CMD_RSVD = 2'b11
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FILL      = 2'd1,
      ST_SWAP_WAIT = 2'd2
   } fb_state_e;

endpackage

// File: rtl/screen_framebuffer_if.sv
// -----------------------------------------------------------------------------
// screen_framebuffer_if
// Bundles the CPU write/command handshakes and the scanner read port of the
// frame store. master = CPU + scanner side, slave = screen_framebuffer.
// -----------------------------------------------------------------------------
interface screen_framebuffer_if;
   import screen_pkg::*;

   // CPU pixel write port
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [PIX_W-1:0]    wr_data;
   // CPU command port
   logic                cmd_valid;
   logic                cmd_ready;
   logic [1:0]          cmd_op;
   logic [PIX_W-1:0]    cmd_data;
   // status
   logic                busy;
   logic                swap_done;
   logic                front_bank;
   // scanner side
   logic                frame_start;
   logic [HALF_AW-1:0]  rd_addr;
   logic [PIX_W-1:0]    rd_data0;
   logic [PIX_W-1:0]    rd_data1;

   modport master (
      output wr_valid, wr_addr, wr_data, cmd_valid, cmd_op, cmd_data,
             frame_start, rd_addr,
      input  wr_ready, cmd_ready, busy, swap_done, front_bank,
             rd_data0, rd_data1
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, cmd_valid, cmd_op, cmd_data,
             frame_start, rd_addr,
      output wr_ready, cmd_ready, busy, swap_done, front_bank,
             rd_data0, rd_data1
   );

endinterface

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// Simple dual-port HALF_SCREEN x PIX_W RAM: one write port, one registered
// read port. Only the read data register is reset; the array is not.
// Ports: clk, rst_n, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
// -----------------------------------------------------------------------------
module fb_ram
   import screen_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_we,
   input  logic [HALF_AW-1:0]  i_waddr,
   input  logic [PIX_W-1:0]    i_wdata,
   input  logic [HALF_AW-1:0]  i_raddr,
   output logic [PIX_W-1:0]    o_rdata
);

   logic [PIX_W-1:0] r_mem [HALF_SCREEN];
   logic [PIX_W-1:0] r_rdata;

   // NOTE: the array has no reset so it maps onto block RAM; resetting it
   // would force it into flops and would also wipe a partial fill.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // NOTE: non-blocking assignments in every clocked block so all registers
   // update together at the edge, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rdata <= '0;
      else        r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/screen_framebuffer.sv
// -----------------------------------------------------------------------------
// screen_framebuffer
// Double-buffered 64x64 RGB444 frame store. The CPU writes pixels or fills the
// back bank; the scanner reads top/bottom pixel pairs from the front bank.
// A swap waits for the scanner's frame_start so no frame shows half-updated.
// Ports: clk, reset (async, active-low), bus (screen_framebuffer_if.slave).
// -----------------------------------------------------------------------------
module screen_framebuffer
   import screen_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   screen_framebuffer_if.slave   bus
);

   fb_state_e           r_state;
   logic [HALF_AW-1:0]  r_fill_cnt;
   logic [PIX_W-1:0]    r_fill_data;
   logic                r_front_bank;
   logic                r_rd_bank;
   logic                r_swap_done;
   logic                r_wr_ready;
   logic                r_cmd_ready;
   logic                r_busy;

   logic                w_wr_fire;
   logic                w_cmd_fire;
   logic                w_fill_active;
   logic                w_back_bank;
   logic [HALF_AW-1:0]  w_waddr;
   logic [PIX_W-1:0]    w_wdata;
   logic [PIX_W-1:0]    w_rdata [2][2];   // [bank][half]

   // Readies are registered, so acceptance never depends combinationally on valid.
   assign w_wr_fire     = bus.wr_valid  & r_wr_ready;
   assign w_cmd_fire    = bus.cmd_valid & r_cmd_ready;
   assign w_fill_active = (r_state == ST_FILL);
   assign w_back_bank   = ~r_front_bank;

   // A fill owns the write port; CPU writes are blocked then by wr_ready=0.
   assign w_waddr = w_fill_active ? r_fill_cnt  : bus.wr_addr[HALF_AW-1:0];
   assign w_wdata = w_fill_active ? r_fill_data : bus.wr_data;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar h = 0; h < 2; h++) begin : g_half
         logic w_we;
         // A fill writes both halves; a pixel write picks its half by addr MSB.
         assign w_we = (w_back_bank == 1'(b)) &&
                       (w_fill_active ||
                        (w_wr_fire && (bus.wr_addr[ADDR_W-1] == 1'(h))));

         fb_ram u_ram (
            .clk     (clk),
            .rst_n   (reset),
            .i_we    (w_we),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (bus.rd_addr),
            .o_rdata (w_rdata[b][h])
         );
      end
   end

   // Bank used for the read in flight: the RAM output after edge N belongs to
   // the bank that was front at edge N, so the select is delayed to match.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rd_bank <= 1'b0;
      else        r_rd_bank <= r_front_bank;
   end

   assign bus.rd_data0 = r_rd_bank ? w_rdata[1][0] : w_rdata[0][0];
   assign bus.rd_data1 = r_rd_bank ? w_rdata[1][1] : w_rdata[0][1];

   // FSM with registered Moore outputs, updated alongside each transition.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_fill_cnt   <= '0;
         r_fill_data  <= '0;
         r_front_bank <= 1'b0;
         r_swap_done  <= 1'b0;
         r_wr_ready   <= 1'b1;
         r_cmd_ready  <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         r_swap_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  case (cmd_op_e'(bus.cmd_op))
                     CMD_FILL: begin
                        r_state     <= ST_FILL;
                        r_fill_cnt  <= '0;
                        r_fill_data <= bus.cmd_data;
                        r_wr_ready  <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                     end
                     CMD_SWAP: begin
                        // frame_start in this same cycle is deliberately ignored
                        r_state     <= ST_SWAP_WAIT;
                        r_wr_ready  <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                     end
                     default: ;  // nop and reserved: accepted, no effect
                  endcase
               end
            end
            ST_FILL: begin
               r_fill_cnt <= r_fill_cnt + 1'b1;
               if (r_fill_cnt == FILL_LAST) begin
                  r_state     <= ST_IDLE;
                  r_wr_ready  <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            ST_SWAP_WAIT: begin
               if (bus.frame_start) begin
                  r_front_bank <= ~r_front_bank;
                  r_swap_done  <= 1'b1;
                  r_state      <= ST_IDLE;
                  r_wr_ready   <= 1'b1;
                  r_cmd_ready  <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wr_ready   = r_wr_ready;
   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.busy       = r_busy;
   assign bus.swap_done  = r_swap_done;
   assign bus.front_bank = r_front_bank;

endmodule

// File: tb/tb_screen_framebuffer.sv
// -----------------------------------------------------------------------------
// tb_screen_framebuffer
// Directed bench for screen_framebuffer. A bank/half pixel model tracks what
// each bank should hold; every read pushes its expected pair to a queue that
// is popped when the registered read data appears one cycle later.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_screen_framebuffer;
   import screen_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   screen_framebuffer_if bus ();

   screen_framebuffer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int               addr;
      logic [PIX_W-1:0] exp0;
      logic [PIX_W-1:0] exp1;
   } rd_exp_t;

   rd_exp_t          sb [$];
   logic [PIX_W-1:0] mdl [2][2*HALF_SCREEN];   // [bank][full pixel index]
   logic             mfront;
   int               n_tests = 0;
   int               n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input cmd_op_e op, input logic [PIX_W-1:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = CMD_NOP;
   endtask

   task automatic write_px(input int addr, input logic [PIX_W-1:0] data);
      check("wr_ready_before_write", bus.wr_ready, 1);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = ADDR_W'(addr);
      bus.wr_data  = data;
      mdl[mfront ^ 1'b1][addr] = data;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   // Commits a pending swap with a frame_start pulse and checks the commit.
   task automatic pulse_commit(input string tag);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
      mfront ^= 1'b1;
      check({tag, "_front_bank"}, bus.front_bank, 32'(mfront));
      check({tag, "_swap_done"},  bus.swap_done, 1);
      check({tag, "_busy_after"}, bus.busy, 0);
      @(negedge clk);
      check({tag, "_swap_done_pulse"}, bus.swap_done, 0);
   endtask

   task automatic read_sweep(input string tag, input int lo, input int hi);
      for (int a = lo; a <= hi; a++) begin
         rd_exp_t e;
         bus.rd_addr = HALF_AW'(a);
         e.addr = a;
         e.exp0 = mdl[mfront][a];
         e.exp1 = mdl[mfront][a + HALF_SCREEN];
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         check($sformatf("%s_d0[%0d]", tag, e.addr), bus.rd_data0, e.exp0);
         check($sformatf("%s_d1[%0d]", tag, e.addr), bus.rd_data1, e.exp1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      int bad_ready;
      int bad_front;

      reset           = 1'b0;
      bus.wr_valid    = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = CMD_NOP;
      bus.cmd_data    = '0;
      bus.frame_start = 1'b0;
      bus.rd_addr     = '0;
      mfront          = 1'b0;

      // ---- reset values
      repeat (3) @(negedge clk);
      check("rst_wr_ready",   bus.wr_ready, 1);
      check("rst_cmd_ready",  bus.cmd_ready, 1);
      check("rst_busy",       bus.busy, 0);
      check("rst_swap_done",  bus.swap_done, 0);
      check("rst_front_bank", bus.front_bank, 0);
      check("rst_rd_data0",   bus.rd_data0, 0);
      check("rst_rd_data1",   bus.rd_data1, 0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_wr_ready", bus.wr_ready, 1);
      check("post_rst_busy",     bus.busy, 0);

      // ---- pixel writes, swap, readback
      write_px(5, 12'hF00);
      write_px(2053, 12'h00F);
      send_cmd(CMD_SWAP, '0);
      check("swap_busy",      bus.busy, 1);
      check("swap_wr_ready",  bus.wr_ready, 0);
      check("swap_cmd_ready", bus.cmd_ready, 0);
      check("swap_front_old", bus.front_bank, 0);
      pulse_commit("swap1");
      read_sweep("px", 5, 5);

      // ---- fill: busy for exactly 2048 cycles, wr_ready low throughout
      send_cmd(CMD_FILL, 12'h0A0);
      for (int i = 0; i < 2 * HALF_SCREEN; i++) mdl[mfront ^ 1'b1][i] = 12'h0A0;
      busy_cycles = 0;
      bad_ready   = 0;
      while (bus.busy && busy_cycles < 3000) begin
         if (bus.wr_ready || bus.cmd_ready) bad_ready++;
         busy_cycles++;
         @(negedge clk);
      end
      check("fill_busy_cycles", busy_cycles, 2048);
      check("fill_ready_low",   bad_ready, 0);
      check("fill_done_ready",  bus.wr_ready, 1);
      send_cmd(CMD_SWAP, '0);
      pulse_commit("swap_fill");
      read_sweep("fill", 0, HALF_SCREEN - 1);

      // ---- long swap wait: writes blocked, front bank held
      send_cmd(CMD_SWAP, '0);
      bus.wr_valid = 1'b1;          // must not be accepted while waiting
      bus.wr_addr  = 12'd5;
      bus.wr_data  = 12'h123;
      bad_ready = 0;
      bad_front = 0;
      for (int i = 0; i < 500; i++) begin
         if (bus.wr_ready || bus.cmd_ready) bad_ready++;
         if (bus.front_bank !== mfront) bad_front++;
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      check("wait_ready_low",  bad_ready, 0);
      check("wait_front_held", bad_front, 0);
      pulse_commit("swap_wait");
      read_sweep("wait", 5, 5);

      // ---- frame_start coincident with swap acceptance is ignored
      bus.frame_start = 1'b1;
      send_cmd(CMD_SWAP, '0);
      bus.frame_start = 1'b0;
      check("coinc_front_held", bus.front_bank, 32'(mfront));
      check("coinc_swap_done",  bus.swap_done, 0);
      check("coinc_busy",       bus.busy, 1);
      repeat (3) @(negedge clk);
      check("coinc_still_busy", bus.busy, 1);
      pulse_commit("swap_coinc");

      // ---- write and swap accepted together: write lands in old back bank
      write_px(2055, 12'h0FF);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 12'd7;
      bus.wr_data  = 12'h5A5;
      mdl[mfront ^ 1'b1][7] = 12'h5A5;
      send_cmd(CMD_SWAP, '0);
      bus.wr_valid = 1'b0;
      check("both_busy", bus.busy, 1);
      pulse_commit("swap_both");
      read_sweep("both", 5, 7);

      // ---- nop and reserved opcodes accepted with no effect
      send_cmd(CMD_NOP, 12'hFFF);
      check("nop_busy",      bus.busy, 0);
      check("nop_cmd_ready", bus.cmd_ready, 1);
      send_cmd(CMD_RSVD, 12'hFFF);
      check("rsvd_busy",     bus.busy, 0);
      check("rsvd_wr_ready", bus.wr_ready, 1);
      check("rsvd_front",    bus.front_bank, 32'(mfront));

      // ---- reset after 100 fill cycles leaves indices 0..99 filled
      send_cmd(CMD_FILL, 12'h3C3);
      repeat (100) @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         mdl[mfront ^ 1'b1][i]               = 12'h3C3;
         mdl[mfront ^ 1'b1][i + HALF_SCREEN] = 12'h3C3;
      end
      check("prefill_busy", bus.busy, 1);
      reset = 1'b0;
      #1;
      check("abort_busy",     bus.busy, 0);
      check("abort_front",    bus.front_bank, 0);
      check("abort_rd_data0", bus.rd_data0, 0);
      mfront = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_wr_ready",  bus.wr_ready, 1);
      check("abort_cmd_ready", bus.cmd_ready, 1);
      check("abort_idle_busy", bus.busy, 0);
      read_sweep("abort", 0, HALF_SCREEN - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
